// File: rtl/am_memsys_pkg.sv
// Shared widths, memory depth and loader/run state encodings for the
// accumulator-machine memory subsystem.
package am_memsys_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 8;
  localparam int OPCODE_W = 4;
  localparam int INST_W   = 12;
  // DEPTH equals 2**ADDR_W, so address wrap comes for free from the index width.
  localparam int DEPTH    = 256;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/am_memsys_ram.sv
// Single-write-port RAM with combinational read and no reset, so contents
// survive both system reset and reload.
module am_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/am_memsys.sv
// Memory subsystem for the accumulator machine: a loader fills imem/dmem in
// LOAD, then the CPU is released from reset and runs against them in RUN.
module am_memsys
  import am_memsys_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic                ld_sel,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [INST_W-1:0]   ld_data,
  input  logic                ld_done,
  input  logic                reload,
  output logic                cpu_rst_n,
  input  logic [ADDR_W-1:0]   pcout,
  output logic [OPCODE_W-1:0] opcode,
  output logic [ADDR_W-1:0]   operand,
  output logic [DATA_W-1:0]   ddatain,
  input  logic [DATA_W-1:0]   accum,
  input  logic                we,
  output logic                running,
  output logic [7:0]          wr_cnt
);

  state_t state, state_nxt;

  logic              ld_write;
  logic              imem_we;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_waddr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [INST_W-1:0] instr;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_nxt;
  end

  // Only the current state picks the transition, so reload and ld_done
  // arriving together never conflict.
  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    running   = 1'b0;
    case (state)
      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid && ld_done) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        running = 1'b1;
        if (reload) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cpu_rst_n <= 1'b0;
    else     cpu_rst_n <= (state_nxt == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst)
      wr_cnt <= 8'h00;
    else if (state == ST_LOAD && state_nxt == ST_RUN)
      wr_cnt <= 8'h00;
    else if (state == ST_RUN && we && wr_cnt != 8'hFF)
      wr_cnt <= wr_cnt + 8'h01;
  end

  // rst gates every write so a reset cycle never disturbs memory contents.
  assign ld_write   = !rst && (state == ST_LOAD) && ld_valid && ld_ready && !ld_done;
  assign imem_we    = ld_write && !ld_sel;
  assign dmem_we    = (ld_write && ld_sel) || (!rst && (state == ST_RUN) && we);
  assign dmem_waddr = (state == ST_RUN) ? operand : ld_addr;
  assign dmem_wdata = (state == ST_RUN) ? accum : ld_data[DATA_W-1:0];

  am_ram #(.WIDTH(INST_W), .DEPTH(DEPTH)) u_imem (
    .clk   (clk),
    .we    (imem_we),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (pcout),
    .rdata (instr)
  );

  am_ram #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_dmem (
    .clk   (clk),
    .we    (dmem_we),
    .waddr (dmem_waddr),
    .wdata (dmem_wdata),
    .raddr (operand),
    .rdata (ddatain)
  );

  assign opcode  = instr[INST_W-1 -: OPCODE_W];
  assign operand = instr[ADDR_W-1:0];

endmodule

// File: tb/tb_am_memsys.sv
// Directed self-checking bench for am_memsys: load, run, saturation,
// reload and mid-load/mid-run reset scenarios.
module tb_am_memsys;
  import am_memsys_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                ld_valid;
  logic                ld_ready;
  logic                ld_sel;
  logic [ADDR_W-1:0]   ld_addr;
  logic [INST_W-1:0]   ld_data;
  logic                ld_done;
  logic                reload;
  logic                cpu_rst_n;
  logic [ADDR_W-1:0]   pcout;
  logic [OPCODE_W-1:0] opcode;
  logic [ADDR_W-1:0]   operand;
  logic [DATA_W-1:0]   ddatain;
  logic [DATA_W-1:0]   accum;
  logic                we;
  logic                running;
  logic [7:0]          wr_cnt;

  int nCompared = 0;
  int nMismatched = 0;

  am_memsys dut (
    .clk       (clk),
    .rst       (rst),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_sel    (ld_sel),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_done   (ld_done),
    .reload    (reload),
    .cpu_rst_n (cpu_rst_n),
    .pcout     (pcout),
    .opcode    (opcode),
    .operand   (operand),
    .ddatain   (ddatain),
    .accum     (accum),
    .we        (we),
    .running   (running),
    .wr_cnt    (wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One loader beat held for a single clock edge.
  task automatic applyStimulus(input logic sel, input logic [7:0] addr,
                               input logic [11:0] data);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_addr  = addr;
    ld_data  = data;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic finishLoad();
    ld_valid = 1'b1;
    ld_done  = 1'b1;
    tick();
    ld_valid = 1'b0;
    ld_done  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ld_valid = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    ld_done = 1'b0; reload = 1'b0; pcout = '0; accum = '0; we = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_ld_ready", 32'(ld_ready), 32'd1);
    checkOutput("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    checkOutput("rst_running", 32'(running), 32'd0);
    checkOutput("rst_wr_cnt", 32'(wr_cnt), 32'd0);

    applyStimulus(1'b0, 8'd0, 12'h105);
    applyStimulus(1'b1, 8'd5, 12'h03C);
    applyStimulus(1'b0, 8'd1, 12'h302);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    checkOutput("reload_in_load", 32'(ld_ready), 32'd1);
    finishLoad();
    checkOutput("run_running", 32'(running), 32'd1);
    checkOutput("run_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    checkOutput("run_ld_ready", 32'(ld_ready), 32'd0);
    checkOutput("run_opcode", 32'(opcode), 32'h1);
    checkOutput("run_operand", 32'(operand), 32'h05);
    checkOutput("run_ddatain", 32'(ddatain), 32'h3C);
    checkOutput("run_wr_cnt", 32'(wr_cnt), 32'd0);

    accum = 8'hA7; we = 1'b1;
    tick();
    we = 1'b0;
    checkOutput("we_ddatain", 32'(ddatain), 32'hA7);
    checkOutput("we_wr_cnt", 32'(wr_cnt), 32'd1);

    accum = 8'h5A; we = 1'b1;
    for (int i = 0; i < 253; i++) tick();
    checkOutput("cnt_fe", 32'(wr_cnt), 32'hFE);
    for (int i = 0; i < 47; i++) tick();
    we = 1'b0;
    checkOutput("cnt_sat", 32'(wr_cnt), 32'hFF);
    checkOutput("sat_ddatain", 32'(ddatain), 32'h5A);

    pcout = 8'd1;
    #1;
    checkOutput("pc1_operand", 32'(operand), 32'h02);
    accum = 8'h11; we = 1'b1; reload = 1'b1;
    tick();
    we = 1'b0; reload = 1'b0;
    checkOutput("reload_running", 32'(running), 32'd0);
    checkOutput("reload_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    checkOutput("reload_ld_ready", 32'(ld_ready), 32'd1);
    checkOutput("reload_we_done", 32'(ddatain), 32'h11);
    accum = 8'hEE; we = 1'b1;
    tick();
    we = 1'b0;
    checkOutput("load_we_ignored", 32'(ddatain), 32'h11);
    finishLoad();
    checkOutput("rerun_running", 32'(running), 32'd1);
    checkOutput("rerun_wr_cnt", 32'(wr_cnt), 32'd0);

    accum = 8'h99; we = 1'b1; rst = 1'b1;
    tick();
    we = 1'b0; rst = 1'b0;
    checkOutput("midrun_rst_running", 32'(running), 32'd0);
    checkOutput("midrun_rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    checkOutput("midrun_rst_wr_cnt", 32'(wr_cnt), 32'd0);
    checkOutput("midrun_rst_we_dropped", 32'(ddatain), 32'h11);

    applyStimulus(1'b0, 8'd2, 12'h20A);
    applyStimulus(1'b0, 8'd3, 12'h40B);
    applyStimulus(1'b1, 8'd10, 12'h077);
    ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 8'd10; ld_data = 12'h000; rst = 1'b1;
    tick();
    ld_valid = 1'b0; rst = 1'b0;
    checkOutput("midload_rst_ld_ready", 32'(ld_ready), 32'd1);
    finishLoad();
    pcout = 8'd2;
    #1;
    checkOutput("keep_opcode2", 32'(opcode), 32'h2);
    checkOutput("keep_operand2", 32'(operand), 32'h0A);
    checkOutput("keep_dmem10", 32'(ddatain), 32'h77);
    pcout = 8'd3;
    #1;
    checkOutput("keep_instr3", 32'({opcode, operand}), 32'h40B);

    pcout = 8'd2;
    applyStimulus(1'b1, 8'd10, 12'h0AA);
    applyStimulus(1'b0, 8'd2, 12'hFFF);
    checkOutput("run_ld_no_dmem", 32'(ddatain), 32'h77);
    checkOutput("run_ld_no_imem", 32'({opcode, operand}), 32'h20A);

    ld_valid = 1'b1; ld_done = 1'b1; reload = 1'b1;
    tick();
    ld_valid = 1'b0; ld_done = 1'b0; reload = 1'b0;
    checkOutput("both_in_run", 32'(running), 32'd0);
    ld_valid = 1'b1; ld_done = 1'b1; reload = 1'b1;
    tick();
    ld_valid = 1'b0; ld_done = 1'b0; reload = 1'b0;
    checkOutput("both_in_load", 32'(running), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
